// File: rtl/pipe_adder.sv
// pipe_adder: handshaked, segment-pipelined ripple-carry adder/subtractor.
// WIDTH bits are split into STAGES = WIDTH/SEG segments, one register stage each.
// Optional scan threading of valid/carry flops when PIPE_ADDER_SCAN_EN is defined.
module pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef PIPE_ADDER_SCAN_EN
    ,
    input  logic             test_si,
    input  logic             test_se,
    output logic             test_so
`endif
);

    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int unsigned CTL_W  = 2 * STAGES;

    logic              advance;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [CTL_W-1:0]  ctl_q;
    logic [CTL_W-1:0]  ctl_d;
    logic              ovf_d;
    logic              ovf_q;

    // x carries finished sum segments (low) and not-yet-added A segments (high);
    // y carries the not-yet-added B' segments, cleared once consumed.
    logic [WIDTH-1:0]  x_d [STAGES];
    logic [WIDTH-1:0]  y_d [STAGES];
    logic [WIDTH-1:0]  x_q [STAGES];
    logic [WIDTH-1:0]  y_q [STAGES];

    // Control flops: valid bits low, segment carries high (top carry is cout).
    assign v_q = ctl_q[STAGES-1:0];
    assign c_q = ctl_q[CTL_W-1:STAGES];

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign sum       = x_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    // Per-segment adders; stage 0 applies the subtract inversion.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k * SEG);

        logic [WIDTH-1:0] xi;
        logic [WIDTH-1:0] yi;
        logic             ci;
        logic             vi;
        logic [SEG:0]     seg_sum;

        if (k == 0) begin : g_first
            assign xi = a;
            assign yi = b ^ {WIDTH{sub}};
            assign ci = cin ^ sub;
            assign vi = in_valid;
        end else begin : g_next
            assign xi = x_q[k-1];
            assign yi = y_q[k-1];
            assign ci = c_q[k-1];
            assign vi = v_q[k-1];
        end

        assign seg_sum = (SEG+1)'(xi[k*SEG +: SEG]) + (SEG+1)'(yi[k*SEG +: SEG])
                       + (SEG+1)'(ci);
        assign x_d[k]  = (xi & ~SEG_MASK) | (WIDTH'(seg_sum[SEG-1:0]) << (k * SEG));
        assign y_d[k]  = yi & ~SEG_MASK;
        assign c_d[k]  = seg_sum[SEG];
        assign v_d[k]  = vi;

        if (k == STAGES - 1) begin : g_last
            // Signed overflow: like-signed operands giving an opposite-signed sum.
            assign ovf_d = (xi[WIDTH-1] == yi[WIDTH-1]) && (seg_sum[SEG-1] != xi[WIDTH-1]);
        end
    end

    // Next value of valid/carry flops: functional shift or scan shift.
    always_comb begin
        ctl_d = ctl_q;
        if (advance) begin
            ctl_d = {c_d, v_d};
        end
`ifdef PIPE_ADDER_SCAN_EN
        if (test_se) begin
            ctl_d[0] = test_si;
            for (int unsigned i = 1; i < CTL_W - 1; i++) begin
                ctl_d[i] = ctl_q[i-1];
            end
            ctl_d[CTL_W-1] = ctl_q[CTL_W-1];
        end
`endif
    end

`ifdef PIPE_ADDER_SCAN_EN
    assign test_so = ctl_q[CTL_W-2];
`endif

    // Valid and carry registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_q <= '0;
        end else begin
            ctl_q <= ctl_d;
        end
    end

    // Operand skew, sum de-skew and overflow registers; hold on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (default WIDTH=16, SEG=4).
module tb_pipe_adder;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cin_i = 1'b0;
    logic         sub_i = 1'b0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         rand_rdy = 1'b0;
    logic         rdy_rand = 1'b1;
    logic         rdy_dir  = 1'b1;
    logic         scan_mode = 1'b0;
`ifdef PIPE_ADDER_SCAN_EN
    logic         test_si = 1'b0;
    logic         test_se = 1'b0;
    logic         test_so;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    assign out_ready = rand_rdy ? rdy_rand : rdy_dir;

    pipe_adder #(.WIDTH(W), .SEG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .sub       (sub_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
`ifdef PIPE_ADDER_SCAN_EN
        ,
        .test_si   (test_si),
        .test_se   (test_se),
        .test_so   (test_so)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic c, input logic s);
        exp_t e;
        int   u;
        int   sr;
        if (!s) begin
            u      = int'(av) + int'(bv) + int'(c);
            sr     = int'($signed(av)) + int'($signed(bv)) + int'(c);
            e.cout = (u > 65535);
        end else begin
            u      = int'(av) - int'(bv) - int'(c);
            sr     = int'($signed(av)) - int'($signed(bv)) - int'(c);
            e.cout = (u >= 0);
        end
        e.sum = W'(u);
        e.ovf = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Offer one beat until accepted; expectation is queued on acceptance.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic c, input logic s);
        int   cyc;
        logic acc;
        a_i = av; b_i = bv; cin_i = c; sub_i = s; in_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!acc && cyc < 100);
        if (acc) exp_q.push_back(model(av, bv, c, s));
        else check("send_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Called right after the accepting edge N: valid only after edge N+3.
    task automatic check_latency(input string name);
        check({name, "_n0"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1; check({name, "_n1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1; check({name, "_n2"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1; check({name, "_n3"}, 32'(out_valid), 32'd1);
    endtask

    // Scoreboard monitor: every presented-and-taken beat is popped and compared.
    always @(negedge clk) begin
        if (rst && !scan_mode && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("beat", 32'({sum, cout, ovf}), 32'({e.sum, e.cout, e.ovf}));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] corner [4];
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sum", 32'(sum), 32'd0);
        @(posedge clk); #1; rst = 1'b1;

        // Carry through every segment, with latency
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check_latency("lat_carry");
        drain();

        // Subtract overflow
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();

        // Back-to-back streaming
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        drain();

        // Backpressure with full pipe
        rdy_dir = 1'b0;
        send(16'h0101, 16'h0202, 1'b1, 1'b0);
        send(16'hA000, 16'h6000, 1'b0, 1'b0);
        send(16'h0010, 16'h0020, 1'b1, 1'b1);
        send(16'h4444, 16'h3333, 1'b0, 1'b1);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        fork
            send(16'hBEEF, 16'h1001, 1'b0, 1'b0);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_out_valid", 32'(out_valid), 32'd1);
                    check("bp_sum_held", 32'(sum), 32'(exp_q[0].sum));
                end
                @(posedge clk); #1;
                rdy_dir = 1'b1;
            end
        join
        drain();

        // Reset with beats in flight
        send(16'h1000, 16'h0001, 1'b0, 1'b0);
        send(16'h2000, 16'h0002, 1'b0, 1'b0);
        send(16'h3000, 16'h0003, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_sum", 32'(sum), 32'd0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(16'h0002, 16'h0003, 1'b0, 1'b0);
        check_latency("lat_post_rst");
        drain();

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ra = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            send(ra, rb, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        rdy_dir  = 1'b1;
        drain();

`ifdef PIPE_ADDER_SCAN_EN
        // Scan chain: 7 flops, pattern reappears 7 edges later
        begin
            logic [6:0] pat;
            pat = 7'b1010110;
            scan_mode = 1'b1;
            test_se   = 1'b1;
            for (int e = 1; e <= 14; e++) begin
                test_si = (e <= 7) ? pat[7-e] : 1'b0;
                @(posedge clk); #1;
                if (e >= 7) check("scan_so", 32'(test_so), 32'(pat[13-e]));
            end
            test_se = 1'b0;
            rst = 1'b0;
            #1;
            check("scan_rst_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            rst = 1'b1;
            scan_mode = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
